// File: rtl/la_program_loader.sv
// Program loader: writes instruction words arriving over a logic-analyser toggle-strobe link into
// the program RAM while holding the CPU core in reset; tracks word count, checksum and order errors.
module la_program_loader #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned RST_HOLD = 4
) (
   input  logic              clock,
   input  logic              resetb,
   input  logic              load_ram,
   input  logic              wr_strobe,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              cpu_rst_n,
   output logic              ack_toggle,
   output logic [ADDR_W:0]   word_count,
   output logic [15:0]       checksum,
   output logic              seq_err
);

   typedef enum logic [1:0] {StHold, StIdle, StLoad, StWrite} state_e;

   localparam int unsigned       HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                strobe_q, strobe_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                ack_q, ack_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [15:0]         sum_q, sum_d;
   logic                err_q, err_d;
   logic                req_valid;
   logic                load_entry;

   // Count is unchanged between LOAD and WRITE, so the latched address can be checked here.
   assign req_valid = !count_q[ADDR_W] && (addr_q == count_q[ADDR_W-1:0]);

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q    <= StHold;
         hold_cnt_q <= '0;
         strobe_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         ack_q      <= 1'b0;
         count_q    <= '0;
         sum_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         strobe_q   <= strobe_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         count_q    <= count_d;
         sum_q      <= sum_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      strobe_d   = strobe_q;
      addr_d     = addr_q;
      data_d     = data_q;
      ack_d      = ack_q;
      count_d    = count_q;
      sum_d      = sum_q;
      err_d      = err_q;
      load_entry = 1'b0;
      ram_we     = 1'b0;
      cpu_rst_n  = 1'b0;

      unique case (state_q)
         StHold: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (load_ram) begin
               state_d    = StLoad;
               load_entry = 1'b1;
            end else if (hold_cnt_q >= HOLD_LAST) begin
               state_d = StIdle;
            end
         end

         StIdle: begin
            cpu_rst_n = 1'b1;
            if (load_ram) begin
               state_d    = StLoad;
               load_entry = 1'b1;
            end
         end

         StLoad: begin
            if (wr_strobe != strobe_q) begin
               strobe_d = wr_strobe;
               addr_d   = wr_addr;
               data_d   = wr_data;
               state_d  = StWrite;
            end else if (!load_ram) begin
               state_d    = StHold;
               hold_cnt_d = '0;
            end
         end

         StWrite: begin
            ram_we = req_valid;
            ack_d  = ~ack_q;
            if (req_valid) begin
               count_d = count_q + 1'b1;
               sum_d   = sum_q + 16'(data_q);
            end else begin
               err_d = 1'b1;
            end
            if (load_ram) begin
               state_d = StLoad;
            end else begin
               state_d    = StHold;
               hold_cnt_d = '0;
            end
         end

         default: begin
            state_d    = StHold;
            hold_cnt_d = '0;
         end
      endcase

      // Capturing the live strobe on entry discards toggles made while the loader was idle.
      if (load_entry) begin
         strobe_d = wr_strobe;
         count_d  = '0;
         sum_d    = '0;
         err_d    = 1'b0;
      end
   end

   assign ram_addr   = addr_q;
   assign ram_wdata  = data_q;
   assign ack_toggle = ack_q;
   assign word_count = count_q;
   assign checksum   = sum_q;
   assign seq_err    = err_q;

   a_we_only_in_write : assert property (@(posedge clock) disable iff (!resetb)
      ram_we |-> (state_q == StWrite));

   a_write_single_cycle : assert property (@(posedge clock) disable iff (!resetb)
      (state_q == StWrite) |=> (state_q != StWrite));

   a_cpu_held_while_loading : assert property (@(posedge clock) disable iff (!resetb)
      (state_q inside {StLoad, StWrite}) |-> !cpu_rst_n);

endmodule

// File: tb/tb_la_program_loader.sv
// Randomised self-checking bench for la_program_loader against a transaction-level model
// of the loader (word counter, running checksum, sticky order error, ack toggle).
module tb_la_program_loader;

   localparam int DEPTH = 256;

   logic        clock;
   logic        resetb;
   logic        load_ram;
   logic        wr_strobe;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic        cpu_rst_n;
   logic        ack_toggle;
   logic [8:0]  word_count;
   logic [15:0] checksum;
   logic        seq_err;

   la_program_loader #(
      .ADDR_W   (8),
      .DATA_W   (16),
      .RST_HOLD (4)
   ) dut (
      .clock      (clock),
      .resetb     (resetb),
      .load_ram   (load_ram),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .ack_toggle (ack_toggle),
      .word_count (word_count),
      .checksum   (checksum),
      .seq_err    (seq_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          n_cmp = 0;
   int          n_err = 0;
   int          m_count = 0;
   logic [15:0] m_sum = '0;
   logic        m_err = 1'b0;
   logic        m_ack = 1'b0;
   int          m_we_total = 0;
   int          we_seen = 0;

   always @(posedge clock) begin
      if (ram_we) we_seen <= we_seen + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_valid(input logic [7:0] a);
      return (m_count < DEPTH) && (a == 8'(m_count));
   endfunction

   task automatic model_commit(input logic [7:0] a, input logic [15:0] d);
      if (model_valid(a)) begin
         m_count++;
         m_sum = m_sum + d;
         m_we_total++;
      end else begin
         m_err = 1'b1;
      end
      m_ack = ~m_ack;
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_count"}, 32'(word_count), 32'(m_count));
      check_eq({tag, "_sum"}, 32'(checksum), 32'(m_sum));
      check_eq({tag, "_err"}, 32'(seq_err), 32'(m_err));
      check_eq({tag, "_ack"}, 32'(ack_toggle), 32'(m_ack));
   endtask

   // Counts sampled cycles with cpu_rst_n low; bounded so a stuck reset cannot hang the run.
   task automatic measure_hold(input string tag, input bit skip_first);
      int n;
      if (skip_first) @(negedge clock);
      n = 0;
      while (cpu_rst_n == 1'b0 && n < 20) begin
         check_eq({tag, "_no_we"}, 32'(ram_we), 32'd0);
         n++;
         @(negedge clock);
      end
      check_eq({tag, "_hold_cycles"}, 32'(n), 32'd4);
   endtask

   task automatic start_load();
      if ($urandom_range(0, 1) == 1) wr_strobe = ~wr_strobe;
      @(negedge clock);
      if ($urandom_range(0, 1) == 1) wr_strobe = ~wr_strobe;
      load_ram = 1'b1;
      @(negedge clock);
      m_count = 0;
      m_sum   = '0;
      m_err   = 1'b0;
      check_eq("load_cpu_rst", 32'(cpu_rst_n), 32'd0);
      check_state("load_entry");
   endtask

   task automatic end_load(input string tag);
      load_ram = 1'b0;
      measure_hold(tag, 1'b1);
      check_state({tag, "_after"});
   endtask

   task automatic send(input logic [7:0] a, input logic [15:0] d, input bit drop);
      logic v;
      v = model_valid(a);
      wr_addr   = a;
      wr_data   = d;
      wr_strobe = ~wr_strobe;
      @(negedge clock);
      check_eq("we_pulse", 32'(ram_we), 32'(v));
      check_eq("ack_early", 32'(ack_toggle), 32'(m_ack));
      check_eq("ram_addr", 32'(ram_addr), 32'(a));
      check_eq("ram_wdata", 32'(ram_wdata), 32'(d));
      if (drop) load_ram = 1'b0;
      @(negedge clock);
      model_commit(a, d);
      check_eq("we_single", 32'(ram_we), 32'd0);
      check_state("txn");
   endtask

   task automatic send_in_write(input logic [7:0] a1, input logic [15:0] d1,
                                input logic [7:0] a2, input logic [15:0] d2);
      logic v1, v2;
      v1 = model_valid(a1);
      wr_addr   = a1;
      wr_data   = d1;
      wr_strobe = ~wr_strobe;
      @(negedge clock);
      check_eq("b2b_we1", 32'(ram_we), 32'(v1));
      wr_addr   = a2;
      wr_data   = d2;
      wr_strobe = ~wr_strobe;
      @(negedge clock);
      model_commit(a1, d1);
      check_eq("b2b_gap", 32'(ram_we), 32'd0);
      check_state("b2b_first");
      v2 = model_valid(a2);
      @(negedge clock);
      check_eq("b2b_we2", 32'(ram_we), 32'(v2));
      check_eq("b2b_addr2", 32'(ram_addr), 32'(a2));
      check_eq("b2b_data2", 32'(ram_wdata), 32'(d2));
      @(negedge clock);
      model_commit(a2, d2);
      check_state("b2b_second");
   endtask

   initial begin
      logic [7:0]  a;
      logic [15:0] d;
      resetb    = 1'b0;
      load_ram  = 1'b0;
      wr_strobe = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      repeat (3) @(negedge clock);
      check_eq("rst_cpu", 32'(cpu_rst_n), 32'd0);
      check_eq("rst_we", 32'(ram_we), 32'd0);
      check_state("rst");

      resetb = 1'b1;
      measure_hold("por", 1'b0);
      check_eq("por_idle", 32'(cpu_rst_n), 32'd1);
      check_eq("por_no_writes", 32'(we_seen), 32'd0);

      // Four ordered words.
      start_load();
      send(8'd0, 16'h1111, 1'b0);
      send(8'd1, 16'h2222, 1'b0);
      send(8'd2, 16'h3333, 1'b0);
      send(8'd3, 16'h4444, 1'b0);
      check_eq("four_sum", 32'(checksum), 32'h0000_AAAA);
      check_eq("four_count", 32'(word_count), 32'd4);
      end_load("four");

      // Out-of-order address.
      start_load();
      send(8'd0, 16'h1234, 1'b0);
      send(8'd2, 16'h5678, 1'b0);
      check_eq("skip_err", 32'(seq_err), 32'd1);
      check_eq("skip_count", 32'(word_count), 32'd1);
      end_load("skip");

      // Fill the whole RAM, then overflow.
      start_load();
      for (int i = 0; i < DEPTH; i++) send(8'(i), 16'h0001, 1'b0);
      send(8'd0, 16'h0001, 1'b0);
      check_eq("full_count", 32'(word_count), 32'd256);
      check_eq("full_sum", 32'(checksum), 32'h0000_0100);
      check_eq("full_err", 32'(seq_err), 32'd1);
      end_load("full");

      // Toggle during WRITE, then load_ram dropped during WRITE.
      start_load();
      send(8'd0, 16'hBEEF, 1'b0);
      send_in_write(8'd1, 16'h0102, 8'd2, 16'h0304);
      send(8'd3, 16'hCAFE, 1'b1);
      check_eq("drop_count", 32'(word_count), 32'd4);
      measure_hold("drop", 1'b0);

      // Random traffic, mostly in order.
      start_load();
      for (int i = 0; i < 60; i++) begin
         d = 16'($urandom);
         if ($urandom_range(0, 5) == 0) a = 8'($urandom);
         else a = 8'(m_count);
         send(a, d, 1'b0);
      end
      end_load("rand");

      // Reset asserted in the WRITE cycle.
      start_load();
      send(8'd0, 16'h5A5A, 1'b0);
      wr_addr   = 8'd1;
      wr_data   = 16'hA5A5;
      wr_strobe = ~wr_strobe;
      @(negedge clock);
      check_eq("abort_we_before", 32'(ram_we), 32'd1);
      resetb   = 1'b0;
      load_ram = 1'b0;
      #1;
      m_count = 0;
      m_sum   = '0;
      m_err   = 1'b0;
      m_ack   = 1'b0;
      check_eq("abort_we", 32'(ram_we), 32'd0);
      check_eq("abort_cpu", 32'(cpu_rst_n), 32'd0);
      check_eq("abort_addr", 32'(ram_addr), 32'd0);
      check_eq("abort_data", 32'(ram_wdata), 32'd0);
      check_state("abort");
      repeat (2) @(negedge clock);
      check_eq("abort_no_ack", 32'(ack_toggle), 32'd0);
      resetb = 1'b1;
      measure_hold("abort", 1'b0);

      check_eq("we_total", 32'(we_seen), 32'(m_we_total));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
